exp_arbiter: RTL

EXP_ARBITER -- requirements
Module: exp_arbiter

---
 rtl/exp_arbiter_pkg.sv | 21 ++
 rtl/exp_tag_pipe.sv | 47 ++++
 rtl/exp_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/exp_arbiter_pkg.sv
// exp_arbiter_pkg: global widths, exp latency, default requester count and ring helper.
// Defines `SINGLE, `EXP_LAT and `EXP_N_REQ, so it must be compiled before other files.
`ifndef EXP_ARB_GLOBALS
`define EXP_ARB_GLOBALS
`define SINGLE 32
`define EXP_LAT 17
`define EXP_N_REQ 4
`endif

package exp_arbiter_pkg;

    localparam int SINGLE_W  = `SINGLE;
    localparam int EXP_LAT   = `EXP_LAT;
    localparam int N_REQ_DEF = `EXP_N_REQ;

    // Next position on the ring lo..hi, wrapping hi back to lo.
    function automatic int ring_next(input int cur, input int lo, input int hi);
        return (cur >= hi) ? lo : cur + 1;
    endfunction

endpackage

// File: rtl/exp_tag_pipe.sv
// exp_tag_pipe: LAT-deep {valid,id} shift tracking operations inside the exp pipeline.
module exp_tag_pipe
    import exp_arbiter_pkg::*;
#(
    parameter int LAT = EXP_LAT,
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           in_vld,
    input  logic [IDW-1:0] in_id,
    output logic           out_vld,
    output logic [IDW-1:0] out_id,
    output logic           any_vld
);

    logic [LAT-1:0] vld;
    logic [IDW-1:0] id [LAT];

    // Valid bits advance one stage per cycle; flush empties every stage at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            vld <= '0;
        else if (flush)
            vld <= '0;
        else
            vld <= {vld[LAT-2:0], in_vld};
    end

    // Ids ride alongside the valids and only matter where the matching valid is set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < LAT; s++)
                id[s] <= '0;
        end else begin
            id[0] <= in_id;
            for (int s = 1; s < LAT; s++)
                id[s] <= id[s-1];
        end
    end

    assign out_vld = vld[LAT-1];
    assign out_id  = id[LAT-1];
    assign any_vld = |vld;

endmodule

// File: rtl/exp_arbiter.sv
// exp_arbiter: round-robin sharing of one exp pipeline among N_REQ requesters.
// Optional macro EXP_ARB_FIXED_PRIO_EN: requester 0 always wins, the rest rotate.
module exp_arbiter
    import exp_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int LAT   = EXP_LAT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*`SINGLE-1:0]  x_in,
    output logic [N_REQ-1:0]          gnt,
    output logic [`SINGLE-1:0]        exp_x,
    output logic                      exp_sta,
    input  logic [`SINGLE-1:0]        exp_y,
    output logic [`SINGLE-1:0]        y_out,
    output logic                      y_vld,
    output logic [$clog2(N_REQ)-1:0]  y_id,
    output logic                      busy
);

    localparam int IDW = $clog2(N_REQ);
`ifdef EXP_ARB_FIXED_PRIO_EN
    localparam int LO = 1;
`else
    localparam int LO = 0;
`endif

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] cand;
    logic [IDW-1:0] sel;
    logic           hit;
    logic           issue;
    logic           ptr_upd;
    logic           tag_vld;
    logic [IDW-1:0] tag_id;
    logic           tag_any;
    logic           ret;

    // Search the ring starting just after the last grant; fixed-priority mode lets 0 override.
    always_comb begin
        cand = ptr;
        sel  = '0;
        hit  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IDW'(ring_next(int'(cand), LO, N_REQ - 1));
            if (!hit && req[cand]) begin
                hit = 1'b1;
                sel = cand;
            end
        end
`ifdef EXP_ARB_FIXED_PRIO_EN
        if (req[0]) begin
            hit = 1'b1;
            sel = '0;
        end
`endif
    end

    // Reset is folded in so nothing issues while rst is low.
    assign issue   = hit && !flush && rst;
    assign gnt     = issue ? (N_REQ'(1) << sel) : '0;
    assign exp_sta = issue;
    assign exp_x   = issue ? x_in[int'(sel) * SINGLE_W +: SINGLE_W] : '0;

`ifdef EXP_ARB_FIXED_PRIO_EN
    assign ptr_upd = issue && (sel != '0);
`else
    assign ptr_upd = issue;
`endif

    // Pointer remembers the last granted index; reset value makes requester 0 first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ptr <= IDW'(N_REQ - 1);
        else if (ptr_upd)
            ptr <= sel;
    end

    exp_tag_pipe #(
        .LAT (LAT),
        .IDW (IDW)
    ) u_tag (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .in_vld  (exp_sta),
        .in_id   (sel),
        .out_vld (tag_vld),
        .out_id  (tag_id),
        .any_vld (tag_any)
    );

    // A flush also kills the operation that is just leaving the tag pipe.
    assign ret = tag_vld && !flush;

    // Capture the exp result with its owner; outputs hold between pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y_out <= '0;
            y_id  <= '0;
            y_vld <= 1'b0;
        end else begin
            y_vld <= ret;
            if (ret) begin
                y_out <= exp_y;
                y_id  <= tag_id;
            end
        end
    end

    assign busy = tag_any | y_vld;

endmodule
